// File: rtl/can_frame_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : can_frame_tx_pkg
// Description : Shared CAN 2.0A transmit definitions: FSM state encoding,
//               field lengths, CRC polynomial, stuffing limit, DLC helper.
// Revision    : 1.0 - initial release
// ============================================================================
package can_frame_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD     = 4'd1,
    ST_SOF      = 4'd2,
    ST_ARB      = 4'd3,
    ST_CTRL     = 4'd4,
    ST_DATA     = 4'd5,
    ST_CRC      = 4'd6,
    ST_CRC_DEL  = 4'd7,
    ST_ACK_SLOT = 4'd8,
    ST_ACK_DEL  = 4'd9,
    ST_EOF      = 4'd10,
    ST_IFS      = 4'd11
  } state_t;

  localparam int LEN_ID   = 11;
  localparam int LEN_DLC  = 4;
  localparam int LEN_ARB  = LEN_ID + 1;         // ID + RTR
  localparam int LEN_CTRL = 2 + LEN_DLC;        // IDE + r0 + DLC
  localparam int LEN_CRC  = 15;
  localparam int LEN_EOF  = 7;
  localparam int LEN_IFS  = 3;
  localparam int STUFF_LIMIT = 5;

  // Shift register image: ID, RTR, IDE, r0, DLC, 8 payload bytes
  localparam int SHIFT_W = LEN_ID + 3 + LEN_DLC + 64;

  localparam logic [14:0] CAN_CRC_POLY = 15'h4599;

  // Number of payload bits on the wire; DLC codes above 8 still send 8 bytes
  function automatic logic [6:0] data_bits(input logic [3:0] dlc);
    data_bits = (dlc > 4'd8) ? 7'd64 : {dlc[3:0], 3'b000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/can_frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : can_frame_tx_if
// Description : Host-side command/status bundle of the CAN frame transmitter.
//               Signal directions are named from the transmitter's viewpoint.
// Revision    : 1.0 - initial release
// ============================================================================
interface can_frame_tx_if;
  logic        i_Tx_DV;
  logic [10:0] i_Id;
  logic [3:0]  i_Dlc;
  logic [63:0] i_Data;
  logic        o_Tx_Active;
  logic        o_Tx_Done;
  logic        o_Ack_Err;
  logic        o_Arb_Lost;

  modport master (
    output i_Tx_DV, i_Id, i_Dlc, i_Data,
    input  o_Tx_Active, o_Tx_Done, o_Ack_Err, o_Arb_Lost
  );

  modport slave (
    input  i_Tx_DV, i_Id, i_Dlc, i_Data,
    output o_Tx_Active, o_Tx_Done, o_Ack_Err, o_Arb_Lost
  );
endinterface
`default_nettype wire

// File: rtl/can_crc15.sv
`default_nettype none
// ============================================================================
// Module      : can_crc15
// Description : Serial CAN CRC-15 (poly 0x4599, init 0), one bit per bit_en.
// Revision    : 1.0 - initial release
// ============================================================================
module can_crc15
  import can_frame_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_L,
  input  logic        clear,
  input  logic        bit_en,
  input  logic        bit_in,
  output logic [14:0] crc
);

  logic [14:0] r_crc;
  logic        w_fb;

  assign w_fb = bit_in ^ r_crc[14];
  assign crc  = r_crc;

  // CRC register: cleared per frame, advanced once per fed bit
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_crc <= '0;
    end else if (clear) begin
      r_crc <= '0;
    end else if (bit_en) begin
      r_crc <= {r_crc[13:0], 1'b0} ^ (w_fb ? CAN_CRC_POLY : 15'd0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/can_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : can_frame_tx
// Description : Serialises one CAN 2.0A standard data frame with bit
//               stuffing, CRC-15 and ACK-slot check. The FSM state names
//               the bit currently on the wire; all wire changes happen at
//               the bit-clock wrap. Optional arbitration monitor is built
//               when CAN_ARB_MONITOR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module can_frame_tx
  import can_frame_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int SAMPLE_PT    = 5
)(
  input  logic           i_Clock,
  input  logic           i_Rst_L,
  can_frame_tx_if.slave  bus,
  input  logic           i_Rx_Serial,
  output logic           o_Tx_Serial
);

  localparam int               CNT_W      = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_PT);

  state_t               r_state, w_state_nxt, w_field_nxt;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [6:0]           r_cnt;
  logic [2:0]           r_run;
  logic                 r_tx;
  logic [SHIFT_W-1:0]   r_sh;
  logic [14:0]          r_crc_sh;
  logic [3:0]           r_dlc;
  logic                 r_ack_err;
  logic [14:0]          w_crc;
  logic [6:0]           w_data_bits;
  logic w_bit_end, w_sample, w_accept, w_ins_stuff, w_field_last;
  logic w_arb_lost, w_advance, w_done, w_next_bit, w_crc_en;

  assign w_bit_end   = (r_clk_cnt == CNT_LAST);
  assign w_sample    = (r_clk_cnt == CNT_SAMPLE);
  assign w_accept    = (r_state == ST_IDLE) && bus.i_Tx_DV;
  assign w_data_bits = data_bits(r_dlc);
  // Five identical bits already on the wire inside the stuffed region
  assign w_ins_stuff = (r_state inside {ST_SOF, ST_ARB, ST_CTRL, ST_DATA, ST_CRC}) &&
                       (r_run == 3'(STUFF_LIMIT));
  assign w_crc_en    = w_advance && (w_state_nxt inside {ST_SOF, ST_ARB, ST_CTRL, ST_DATA});

  assign o_Tx_Serial     = r_tx;
  assign bus.o_Tx_Active = !(r_state inside {ST_IDLE, ST_LOAD});
  assign bus.o_Tx_Done   = w_done;
  assign bus.o_Ack_Err   = w_done & r_ack_err;
  assign bus.o_Arb_Lost  = w_arb_lost;

`ifdef CAN_ARB_MONITOR_EN
  logic r_stuff;

  // Remember whether the current wire bit is a stuff bit (exempt from monitoring)
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L)                    r_stuff <= 1'b0;
    else if (w_arb_lost)             r_stuff <= 1'b0;
    else if (w_bit_end && w_ins_stuff) r_stuff <= 1'b1;
    else if (w_advance)              r_stuff <= 1'b0;
  end

  assign w_arb_lost = (r_state == ST_ARB) && w_sample && r_tx && !i_Rx_Serial && !r_stuff;
`else
  assign w_arb_lost = 1'b0;
`endif

  can_crc15 u_crc (
    .clk    (i_Clock),
    .rst_L  (i_Rst_L),
    .clear  (w_accept),
    .bit_en (w_crc_en),
    .bit_in (w_next_bit),
    .crc    (w_crc)
  );

  // Field length decode: is the current bit the last of its field, and what follows
  always_comb begin
    w_field_last = 1'b1;
    w_field_nxt  = ST_IDLE;
    case (r_state)
      ST_SOF:      w_field_nxt = ST_ARB;
      ST_ARB:      begin w_field_last = (r_cnt == 7'(LEN_ARB - 1));  w_field_nxt = ST_CTRL; end
      ST_CTRL:     begin
                     w_field_last = (r_cnt == 7'(LEN_CTRL - 1));
                     w_field_nxt  = (w_data_bits == 7'd0) ? ST_CRC : ST_DATA;
                   end
      ST_DATA:     begin w_field_last = (r_cnt == w_data_bits - 7'd1); w_field_nxt = ST_CRC; end
      ST_CRC:      begin w_field_last = (r_cnt == 7'(LEN_CRC - 1));  w_field_nxt = ST_CRC_DEL; end
      ST_CRC_DEL:  w_field_nxt = ST_ACK_SLOT;
      ST_ACK_SLOT: w_field_nxt = ST_ACK_DEL;
      ST_ACK_DEL:  w_field_nxt = ST_EOF;
      ST_EOF:      begin w_field_last = (r_cnt == 7'(LEN_EOF - 1));  w_field_nxt = ST_IFS; end
      ST_IFS:      begin w_field_last = (r_cnt == 7'(LEN_IFS - 1));  w_field_nxt = ST_IDLE; end
      default:     w_field_last = 1'b0;
    endcase
  end

  // Next-state: a normal bit is placed at each bit boundary unless a stuff slot is due
  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.i_Tx_DV) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        w_state_nxt = ST_SOF;
        w_advance   = 1'b1;
      end
      default: begin
        if (w_arb_lost) begin
          w_state_nxt = ST_IDLE;
        end else if (w_bit_end && !w_ins_stuff) begin
          w_advance = 1'b1;
          if (w_field_last) begin
            w_state_nxt = w_field_nxt;
            w_done      = (r_state == ST_IFS);
          end
        end
      end
    endcase
  end

  // Value of the next normal (non-stuff) bit, chosen by the field it belongs to
  always_comb begin
    w_next_bit = 1'b1;
    case (w_state_nxt)
      ST_SOF:                    w_next_bit = 1'b0;
      ST_ARB, ST_CTRL, ST_DATA:  w_next_bit = r_sh[SHIFT_W-1];
      ST_CRC:                    w_next_bit = (r_state == ST_CRC) ? r_crc_sh[14] : w_crc[14];
      default:                   w_next_bit = 1'b1;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Bit clock, field counter, stuff run, shift registers and wire driver
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_clk_cnt <= '0;
      r_cnt     <= '0;
      r_run     <= '0;
      r_tx      <= 1'b1;
      r_sh      <= '0;
      r_crc_sh  <= '0;
      r_dlc     <= '0;
      r_ack_err <= 1'b0;
    end else begin
      if ((r_state inside {ST_IDLE, ST_LOAD}) || (w_state_nxt == ST_IDLE) || w_bit_end)
        r_clk_cnt <= '0;
      else
        r_clk_cnt <= r_clk_cnt + 1'b1;

      if (w_accept) begin
        r_sh      <= {bus.i_Id, 3'b000, bus.i_Dlc, bus.i_Data};
        r_dlc     <= bus.i_Dlc;
        r_ack_err <= 1'b0;
      end else begin
        if (w_advance && (w_state_nxt inside {ST_ARB, ST_CTRL, ST_DATA}))
          r_sh <= {r_sh[SHIFT_W-2:0], 1'b0};
        if ((r_state == ST_ACK_SLOT) && w_sample)
          r_ack_err <= i_Rx_Serial;
      end

      if (w_arb_lost) begin
        r_tx <= 1'b1;
      end else if (w_bit_end && w_ins_stuff) begin
        r_tx  <= ~r_tx;
        r_run <= 3'd1;
      end else if (w_advance) begin
        r_tx  <= w_next_bit;
        r_run <= ((r_state == ST_LOAD) || (w_next_bit != r_tx)) ? 3'd1 : r_run + 3'd1;
        r_cnt <= (w_state_nxt != r_state) ? 7'd0 : r_cnt + 7'd1;
      end

      if (w_advance && (w_state_nxt == ST_CRC))
        r_crc_sh <= (r_state == ST_CRC) ? {r_crc_sh[13:0], 1'b0} : {w_crc[13:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_can_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_can_frame_tx
// Description : Directed self-checking bench for can_frame_tx
//               (CLKS_PER_BIT=10, SAMPLE_PT=5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_can_frame_tx;

  logic clk;
  logic rst_n;
  logic rx;
  logic tx;

  can_frame_tx_if bus();

  can_frame_tx #(.CLKS_PER_BIT(10), .SAMPLE_PT(5)) dut (
    .i_Clock     (clk),
    .i_Rst_L     (rst_n),
    .bus         (bus.slave),
    .i_Rx_Serial (rx),
    .o_Tx_Serial (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int arb_cnt = 0;
  int active_clks = 0;

  // Pulse/activity counters sampled away from the active edge
  always @(negedge clk) begin
    if (bus.o_Tx_Done === 1'b1)   done_cnt++;
    if (bus.o_Arb_Lost === 1'b1)  arb_cnt++;
    if (bus.o_Tx_Active === 1'b1) active_clks++;
  end

  bit exp_bits[$];
  int ack_idx;

  // Reference wire image: unstuffed header/data, CRC-15, stuffing, trailer
  task automatic build_model(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
    bit          ub[$];
    logic [14:0] crc;
    bit          fb;
    bit          prev;
    int          run;
    int          nb;
    ub = {};
    ub.push_back(1'b0);
    for (int i = 10; i >= 0; i--) ub.push_back(id[i]);
    ub.push_back(1'b0); ub.push_back(1'b0); ub.push_back(1'b0);
    for (int i = 3; i >= 0; i--) ub.push_back(dlc[i]);
    nb = (dlc > 4'd8) ? 8 : int'(dlc);
    for (int i = 0; i < nb * 8; i++) ub.push_back(data[63 - i]);
    crc = 15'd0;
    foreach (ub[i]) begin
      fb  = ub[i] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (fb) crc = crc ^ 15'h4599;
    end
    for (int i = 14; i >= 0; i--) ub.push_back(crc[i]);
    exp_bits = {};
    prev = 1'b1;
    run  = 0;
    foreach (ub[i]) begin
      exp_bits.push_back(ub[i]);
      if (i > 0 && ub[i] == prev) run++;
      else run = 1;
      prev = ub[i];
      if (run == 5) begin
        exp_bits.push_back(!prev);
        prev = !prev;
        run  = 1;
      end
    end
    ack_idx = exp_bits.size() + 1;
    for (int i = 0; i < 13; i++) exp_bits.push_back(1'b1);
  endtask

  // Send one frame, compare every wire bit at mid-bit, then Done/Ack_Err/length
  task automatic run_frame(input string name, input logic [10:0] id, input logic [3:0] dlc,
                           input logic [63:0] data, input bit ack, output int act_clks);
    int bad;
    int first_bad;
    logic got_bit;
    bit   want_bit;
    int d0;
    int a0;
    build_model(id, dlc, data);
    d0 = done_cnt;
    a0 = active_clks;
    @(negedge clk);
    bus.i_Tx_DV = 1'b1; bus.i_Id = id; bus.i_Dlc = dlc; bus.i_Data = data;
    @(negedge clk);
    bus.i_Tx_DV = 1'b0;
    @(posedge clk); #1;
    bad = 0; first_bad = -1; got_bit = 1'b0; want_bit = 1'b0;
    for (int k = 0; k < exp_bits.size(); k++) begin
      rx = (k == ack_idx && ack) ? 1'b0 : exp_bits[k];
      repeat (5) @(posedge clk); #1;
      if (tx !== exp_bits[k] || bus.o_Tx_Active !== 1'b1) begin
        if (bad == 0) begin first_bad = k; got_bit = tx; want_bit = exp_bits[k]; end
        bad++;
      end
      if (k < exp_bits.size() - 1) begin repeat (5) @(posedge clk); #1; end
    end
    rx = 1'b1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s stream: %0d bad bit slots, first at %0d got tx=%b want %b", name, bad, first_bad, got_bit, want_bit);
    end
    repeat (4) @(posedge clk); #1;
    checks++;
    if (bus.o_Tx_Done !== 1'b1) begin
      errors++; $display("FAIL %s done_pulse: got %b want 1", name, bus.o_Tx_Done);
    end
    checks++;
    if (bus.o_Ack_Err !== !ack) begin
      errors++; $display("FAIL %s ack_err: got %b want %b", name, bus.o_Ack_Err, !ack);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.o_Tx_Active !== 1'b0 || bus.o_Tx_Done !== 1'b0) begin
      errors++; $display("FAIL %s idle_after: got active=%b done=%b want 0 0", name, bus.o_Tx_Active, bus.o_Tx_Done);
    end
    act_clks = active_clks - a0;
    checks++;
    if (act_clks != exp_bits.size() * 10) begin
      errors++; $display("FAIL %s length: got %0d clocks want %0d", name, act_clks, exp_bits.size() * 10);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++; $display("FAIL %s done_count: got %0d want 1", name, done_cnt - d0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1;
    bus.i_Tx_DV = 1'b0; bus.i_Id = '0; bus.i_Dlc = '0; bus.i_Data = '0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++;
    if (bus.o_Tx_Active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", bus.o_Tx_Active); end
    checks++;
    if (bus.o_Tx_Done !== 1'b0 || bus.o_Ack_Err !== 1'b0 || bus.o_Arb_Lost !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got done=%b ack=%b arb=%b want 0 0 0", bus.o_Tx_Done, bus.o_Ack_Err, bus.o_Arb_Lost);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (tx !== 1'b1 || bus.o_Tx_Active !== 1'b0) begin
      errors++; $display("FAIL idle_no_request: got tx=%b active=%b want 1 0", tx, bus.o_Tx_Active);
    end
  endtask

  // ID 0, DLC 0: 34 zero bits with 6 stuff bits, 13 recessive bits -> 53 bits
  task automatic test_dlc0_stuff();
    int clks;
    run_frame("dlc0", 11'h000, 4'd0, 64'd0, 1'b1, clks);
    checks++;
    if (clks != 530) begin errors++; $display("FAIL dlc0_hand_length: got %0d clocks want 530", clks); end
  endtask

  task automatic test_id555();
    int clks;
    run_frame("id555", 11'h555, 4'd1, 64'hAA00_0000_0000_0000, 1'b1, clks);
  endtask

  task automatic test_no_ack();
    int clks;
    run_frame("noack", 11'h123, 4'd2, 64'hBEEF_0000_0000_0000, 1'b0, clks);
  endtask

  // DLC 15 sends 8 bytes: at least 111 unstuffed bits
  task automatic test_dlc15();
    int clks;
    run_frame("dlc15", 11'h2C9, 4'd15, 64'h0102_0304_0506_0708, 1'b1, clks);
    checks++;
    if (clks < 1110) begin errors++; $display("FAIL dlc15_min_length: got %0d clocks want >= 1110", clks); end
  endtask

  task automatic test_reset_mid();
    int d0;
    int clks;
    build_model(11'h000, 4'd1, 64'd0);
    d0 = done_cnt;
    @(negedge clk);
    bus.i_Tx_DV = 1'b1; bus.i_Id = 11'h000; bus.i_Dlc = 4'd1; bus.i_Data = 64'd0;
    @(negedge clk);
    bus.i_Tx_DV = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k <= 26; k++) begin
      rx = exp_bits[k];
      repeat (5) @(posedge clk); #1;
      if (k < 26) begin repeat (5) @(posedge clk); #1; end
    end
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL midreset_pre_data: got tx=%b want 0", tx); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || bus.o_Tx_Active !== 1'b0) begin
      errors++; $display("FAIL midreset_async: got tx=%b active=%b want 1 0", tx, bus.o_Tx_Active);
    end
    rx = 1'b1;
    repeat (20) @(posedge clk); #1;
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses want 0", done_cnt - d0); end
    @(negedge clk); rst_n = 1'b1;
    run_frame("after_reset", 11'h3A7, 4'd3, 64'h1234_5600_0000_0000, 1'b1, clks);
  endtask

  task automatic test_back_to_back();
    int clks;
    run_frame("b2b_a", 11'h7FF, 4'd8, 64'hFFFF_FFFF_0000_0000, 1'b1, clks);
    run_frame("b2b_b", 11'h0F0, 4'd4, 64'h8001_7FFE_0000_0000, 1'b1, clks);
  endtask

`ifdef CAN_ARB_MONITOR_EN
  // ID 0x7F0: wire bit 4 is the 4th ID bit (recessive); readback forced dominant
  task automatic test_arb_lost();
    int d0;
    int a0;
    build_model(11'h7F0, 4'd0, 64'd0);
    d0 = done_cnt;
    a0 = arb_cnt;
    @(negedge clk);
    bus.i_Tx_DV = 1'b1; bus.i_Id = 11'h7F0; bus.i_Dlc = 4'd0; bus.i_Data = 64'd0;
    @(negedge clk);
    bus.i_Tx_DV = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k <= 4; k++) begin
      rx = (k == 4) ? 1'b0 : exp_bits[k];
      repeat (5) @(posedge clk); #1;
      if (k < 4) begin repeat (5) @(posedge clk); #1; end
    end
    checks++;
    if (bus.o_Arb_Lost !== 1'b1 || tx !== 1'b1) begin
      errors++; $display("FAIL arb_lost_pulse: got arb=%b tx=%b want 1 1", bus.o_Arb_Lost, tx);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.o_Arb_Lost !== 1'b0 || bus.o_Tx_Active !== 1'b0 || tx !== 1'b1) begin
      errors++; $display("FAIL arb_lost_idle: got arb=%b active=%b tx=%b want 0 0 1", bus.o_Arb_Lost, bus.o_Tx_Active, tx);
    end
    rx = 1'b1;
    repeat (30) @(posedge clk); #1;
    checks++;
    if (done_cnt != d0 || arb_cnt - a0 != 1 || bus.o_Tx_Active !== 1'b0) begin
      errors++; $display("FAIL arb_lost_after: got done=%0d arb=%0d active=%b want 0 1 0", done_cnt - d0, arb_cnt - a0, bus.o_Tx_Active);
    end
  endtask
`else
  task automatic test_arb_lost();
    checks++;
    if (arb_cnt != 0) begin errors++; $display("FAIL arb_tied_low: got %0d pulses want 0", arb_cnt); end
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dlc0_stuff();
    test_id555();
    test_no_ack();
    test_dlc15();
    test_reset_mid();
    test_back_to_back();
    test_arb_lost();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
